// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: one state per cycle, Moore-decoded controls.
// Latency lw 5 / sw,R,addi 4 / beq,j 3 cycles; FETCH, MEMRD and MEMWR stall while mem_ready is low.
module mips_multicycle_control #(
  parameter int COUNT_WIDTH  = 32,
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic [3:0]             state,
  output logic                   illegal_op,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMP   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       fetch;
  } ctrl_t;

  state_t cur;
  ctrl_t  ctrl_q;
  logic   known_op;
  logic   retire;

  function automatic state_t next_of(state_t s, logic [5:0] op, logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXEC;
          OP_BEQ:       n = S_BRANCH;
          OP_J:         n = S_JUMP;
          OP_ADDI:      n = S_ADDI_EX;
          default:      n = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:  n = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   n = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    n = S_RCOMP;
      S_ADDI_EX: n = S_ADDI_WB;
      S_HALT:    n = S_HALT;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:  c.alu_src_b = 2'b11;
      S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:   begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:   begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RCOMP:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB: c.reg_write = 1'b1;
      S_HALT:    c.halted = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  assign known_op = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  assign illegal_op = (cur == S_DECODE) && !known_op;

  // An illegal opcode retires as a NOP only when it does not trap.
  assign retire = (cur == S_MEMWB) || (cur == S_RCOMP) || (cur == S_BRANCH) ||
                  (cur == S_JUMP) || (cur == S_ADDI_WB) ||
                  ((cur == S_MEMWR) && mem_ready) ||
                  (illegal_op && (ILLEGAL_TRAP == 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_FETCH;
      ctrl_q      <= decode(S_FETCH);
      instr_count <= '0;
    end else begin
      cur    <= next_of(cur, opcode, mem_ready);
      ctrl_q <= decode(next_of(cur, opcode, mem_ready));
      if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  // The fetch write strobes follow mem_ready directly so the PC and IR update on the completing cycle.
  assign PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign IRWrite     = ctrl_q.fetch & mem_ready;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign RegWrite    = ctrl_q.reg_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUOp       = ctrl_q.alu_op;
  assign halted      = ctrl_q.halted;
  assign state       = cur;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables and the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = sub, 10 = use funct.
- Adds a memory-ready handshake, an illegal-opcode trap and a retired-instruction counter.

Parameters:
COUNT_WIDTH, 32, width of instr_count
ILLEGAL_TRAP, 0, 0 = illegal opcode treated as NOP; 1 = enter sticky HALT

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes access this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target
ALUSrcB  output  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
ALUOp  output  2  to ALU control decoder
state  output  4  current state encoding (debug)
illegal_op  output  1  one-cycle pulse in DECODE on unknown opcode
halted  output  1  high while in HALT
instr_count  output  COUNT_WIDTH  retired instructions

Behaviour:
- Reset: on a clk edge with rst=1, state<=FETCH(0) and instr_count<=0; rst overrides everything, including mid-access.
- Outputs are Moore decodes of state. Exception: the FETCH/memory gating by mem_ready listed below. Any control not listed for a state is 0.
- Immediately after reset, outputs equal the FETCH decode.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States, outputs and transitions:
  - FETCH(0): MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. -> DECODE if mem_ready, else stay.
  - DECODE(1): ALUSrcB=11, ALUOp=00. Next by opcode: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX.
  - DECODE, other opcode: illegal_op=1. -> FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMRD for lw, MEMWR for sw.
  - MEMRD(3): MemRead=1, IorD=1. -> MEMWB on mem_ready, else stay.
  - MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. -> FETCH on mem_ready, else stay. MemWrite stays high throughout the wait.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RCOMP.
  - RCOMP(7): RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. -> FETCH.
  - ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
  - ADDI_WB(11): RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
  - HALT(12): all controls 0, halted=1. Stays until rst.
  - Encodings 13-15: all controls 0, -> FETCH next cycle.
- instr_count increments by 1 on the edge leaving a completing state: MEMWB, MEMWR (with mem_ready), RCOMP, BRANCH, JUMP, ADDI_WB.
  - Also increments leaving DECODE for an illegal opcode when ILLEGAL_TRAP=0.
  - Wraps modulo 2^COUNT_WIDTH without saturation.
- Latencies with mem_ready tied high, in cycles from FETCH entry: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- opcode is sampled only in DECODE and in MEMADR (lw/sw select). Changes to opcode in other states have no effect.

Test Plan:
- Reset, then lw opcode, mem_ready=1 -> state 0,1,2,3,4,0. IorD=1 in state 3; RegWrite=MemtoReg=1 in state 4; instr_count=1.
- R-type, then beq, then j, mem_ready=1 -> states 0,1,6,7,0,1,8,0,1,9,0. ALUOp=10 in 6, 01 in 8; PCSource=10 in 9; instr_count=3.
- sw with mem_ready low 3 cycles in FETCH and 2 in MEMWR -> PCWrite=IRWrite=0 while waiting. MemWrite high 3 cycles total. Total latency 9 cycles; count +1.
- Opcode 111111, ILLEGAL_TRAP=0 -> illegal_op pulses once in state 1, next state 0, count +1. With ILLEGAL_TRAP=1 -> state 12, halted=1 held 10+ cycles, all controls 0.
- rst asserted in MEMRD with mem_ready=0 -> next edge state=0, instr_count=0, MemRead=1, IorD=0.
- addi back-to-back 4 times -> states repeat 0,1,10,11. ALUSrcB=10 in 10; RegDst=0 and RegWrite=1 in 11; instr_count=4 after 16 cycles.
